// File: rtl/gb_mbc_pkg.sv
// Shared definitions for the Game Boy MBC controller.
//   wr_state_e  : write-strobe FSM states
//   MBC_TYPE_*  : values accepted by the MBC_TYPE parameter
//   RGN*        : register regions decoded from sync A15..A13 / A15..A12
package gb_mbc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COMMIT,
        ST_WAIT_HI
    } wr_state_e;

    localparam int MBC_TYPE_1 = 1;
    localparam int MBC_TYPE_5 = 5;

    // A15..A13 regions (both MBC types)
    localparam logic [2:0] RGN_RAM_EN = 3'b000;
    localparam logic [2:0] RGN_ROM_LO = 3'b001;  // MBC1 low5
    localparam logic [2:0] RGN_RAM_HI = 3'b010;  // MBC5 RAM bank / MBC1 hi2
    localparam logic [2:0] RGN_MODE   = 3'b011;  // MBC1 mode, MBC5 no effect

    // A15..A12 regions (MBC5 ROM bank halves)
    localparam logic [3:0] RGN5_ROM_LO8 = 4'b0010;
    localparam logic [3:0] RGN5_ROM_B8  = 4'b0011;

endpackage

// File: rtl/gb_sync2.sv
// Parametrised-width two-flop synchronizer.
//   clk, rst_n : system clock, synchronous active-low reset (flops reset to all ones)
//   d          : asynchronous input bundle
//   q          : synchronized output bundle
module gb_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '1;
            q  <= '1;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/gb_mbc_ctrl.sv
// Game Boy cartridge memory bank controller (MBC1 / MBC5 register maps).
// Bus writes are synchronized, debounced for SETTLE cycles and committed once
// per write pulse into the bank registers; bank outputs are muxed by raw A14.
//   gb_addr/gb_data/gb_wr_n : raw GB A15..A12, D7..D0, write strobe
//   gb_cs_n                 : raw GB external-RAM select
//   rom_bank, ram_bank      : mapped bank numbers
//   ram_cs_n                : cartridge RAM select (active-low)
//   rumble                  : rumble motor drive (MBC5 with RUMBLE=1 only)
//   cfg_wr                  : one-cycle pulse per register commit
module gb_mbc_ctrl
    import gb_mbc_pkg::*;
#(
    parameter int ROM_BANK_W = 9,
    parameter int RAM_BANK_W = 4,
    parameter int MBC_TYPE   = 5,
    parameter int RUMBLE     = 0,
    parameter int SETTLE     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            gb_addr,
    input  logic [7:0]            gb_data,
    input  logic                  gb_wr_n,
    input  logic                  gb_cs_n,
    output logic [ROM_BANK_W-1:0] rom_bank,
    output logic [RAM_BANK_W-1:0] ram_bank,
    output logic                  ram_cs_n,
    output logic                  rumble,
    output logic                  cfg_wr
);

    logic       wr_n_s;
    logic [3:0] addr_s;
    logic [7:0] data_s;

    gb_sync2 #(.W(1)) u_sync_wr   (.clk(clk), .rst_n(rst_n), .d(gb_wr_n), .q(wr_n_s));
    gb_sync2 #(.W(4)) u_sync_addr (.clk(clk), .rst_n(rst_n), .d(gb_addr), .q(addr_s));
    gb_sync2 #(.W(8)) u_sync_data (.clk(clk), .rst_n(rst_n), .d(gb_data), .q(data_s));

    // The synchronizers hold their reset value (1) for two cycles after
    // release, so wr_n_s is only trusted once warm reaches 2. wr_hi_q then
    // records a genuinely observed high level; a strobe held low across
    // reset release never sets it and so cannot start a write.
    logic [1:0] warm;
    logic       wr_hi_q;
    logic       wr_fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            warm    <= 2'd0;
            wr_hi_q <= 1'b0;
        end else begin
            if (warm != 2'd2)
                warm <= warm + 2'd1;
            wr_hi_q <= (warm == 2'd2) & wr_n_s;
        end
    end

    assign wr_fall = wr_hi_q & ~wr_n_s;

    // ---------------- write FSM ----------------
    wr_state_e  state, state_nx;
    logic [2:0] cnt, cnt_nx;   // low cycles seen so far, including the falling one
    logic       commit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr_fall && !addr_s[3]) begin
                    state_nx = ST_SETTLE;
                    cnt_nx   = 3'd1;
                end
            end
            ST_SETTLE: begin
                if (wr_n_s)
                    state_nx = ST_IDLE;          // glitch: drop without commit
                else if (({1'b0, cnt} + 4'd1) >= 4'(SETTLE))
                    state_nx = ST_COMMIT;
                else
                    cnt_nx = cnt + 3'd1;
            end
            ST_COMMIT: begin
                commit   = 1'b1;
                state_nx = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (wr_n_s)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign cfg_wr = commit;

    // ---------------- bank registers ----------------
    // Kept at full architectural width; outputs truncate to the parameters.
    logic       ram_en;
    logic [8:0] rom5;
    logic [3:0] ram4;
    logic       rumble_r;
    logic [4:0] low5;
    logic [1:0] hi2;
    logic       mode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_en   <= 1'b0;
            rom5     <= 9'd1;
            ram4     <= 4'd0;
            rumble_r <= 1'b0;
            low5     <= 5'd1;
            hi2      <= 2'd0;
            mode     <= 1'b0;
        end else if (commit) begin
            if (addr_s[3:1] == RGN_RAM_EN)
                ram_en <= (data_s[3:0] == 4'hA);
            if (MBC_TYPE == MBC_TYPE_1) begin
                if (addr_s[3:1] == RGN_ROM_LO)
                    low5 <= (data_s[4:0] == 5'd0) ? 5'd1 : data_s[4:0];
                if (addr_s[3:1] == RGN_RAM_HI)
                    hi2 <= data_s[1:0];
                if (addr_s[3:1] == RGN_MODE)
                    mode <= data_s[0];
            end else begin
                if (addr_s == RGN5_ROM_LO8)
                    rom5[7:0] <= data_s;
                if (addr_s == RGN5_ROM_B8)
                    rom5[8] <= data_s[0];
                if (addr_s[3:1] == RGN_RAM_HI) begin
                    ram4 <= data_s[3:0];
                    if (RUMBLE != 0) begin
                        ram4[3]  <= 1'b0;        // bit 3 is the motor, not an address
                        rumble_r <= data_s[3];
                    end
                end
            end
        end
    end

    // ---------------- output mapping ----------------
    // A14 comes straight from the pin: the bank must track the CPU's current
    // access, not the last synchronized write address.
    logic [8:0] rom_full;
    logic [3:0] ram_full;

    always_comb begin
        rom_full = 9'd0;
        ram_full = 4'd0;
        if (MBC_TYPE == MBC_TYPE_1) begin
            if (gb_addr[2])
                rom_full = {2'b00, hi2, low5};
            else if (mode)
                rom_full = {2'b00, hi2, 5'd0};
            ram_full = mode ? {2'b00, hi2} : 4'd0;
        end else begin
            rom_full = gb_addr[2] ? rom5 : 9'd0;
            ram_full = ram4;
        end
    end

    assign rom_bank = rom_full[ROM_BANK_W-1:0];
    assign ram_bank = ram_full[RAM_BANK_W-1:0];
    assign ram_cs_n = ~(ram_en & ~gb_cs_n);
    assign rumble   = (MBC_TYPE == MBC_TYPE_5 && RUMBLE != 0) ? rumble_r : 1'b0;

endmodule

// File: tb/tb_gb_mbc_ctrl.sv
// Bench for gb_mbc_ctrl: three instances (MBC5, MBC1, MBC5+rumble) share one
// GB bus; each is compared against a register-level model of the cartridge.
module tb_gb_mbc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] gb_addr;
    logic [7:0] gb_data;
    logic       gb_wr_n;
    logic       gb_cs_n;

    logic [8:0] rom5_o, rom1_o, romr_o;
    logic [3:0] ram5_o, ram1_o, ramr_o;
    logic       cs5_o, cs1_o, csr_o;
    logic       rum5_o, rum1_o, rumr_o;
    logic       cfg5_o, cfg1_o, cfgr_o;

    always #5 clk = ~clk;

    gb_mbc_ctrl #(.MBC_TYPE(5), .RUMBLE(0)) u_m5 (
        .clk(clk), .rst_n(rst_n), .gb_addr(gb_addr), .gb_data(gb_data),
        .gb_wr_n(gb_wr_n), .gb_cs_n(gb_cs_n), .rom_bank(rom5_o), .ram_bank(ram5_o),
        .ram_cs_n(cs5_o), .rumble(rum5_o), .cfg_wr(cfg5_o));

    gb_mbc_ctrl #(.MBC_TYPE(1), .RUMBLE(0)) u_m1 (
        .clk(clk), .rst_n(rst_n), .gb_addr(gb_addr), .gb_data(gb_data),
        .gb_wr_n(gb_wr_n), .gb_cs_n(gb_cs_n), .rom_bank(rom1_o), .ram_bank(ram1_o),
        .ram_cs_n(cs1_o), .rumble(rum1_o), .cfg_wr(cfg1_o));

    gb_mbc_ctrl #(.MBC_TYPE(5), .RUMBLE(1)) u_mr (
        .clk(clk), .rst_n(rst_n), .gb_addr(gb_addr), .gb_data(gb_data),
        .gb_wr_n(gb_wr_n), .gb_cs_n(gb_cs_n), .rom_bank(romr_o), .ram_bank(ramr_o),
        .ram_cs_n(csr_o), .rumble(rumr_o), .cfg_wr(cfgr_o));

    int n_run  = 0;
    int n_fail = 0;
    int n5 = 0, n1 = 0, nr = 0;   // cfg_wr pulse counters

    always @(posedge clk) begin
        if (cfg5_o) n5 <= n5 + 1;
        if (cfg1_o) n1 <= n1 + 1;
        if (cfgr_o) nr <= nr + 1;
    end

    // ---------------- reference model ----------------
    int m5_en, m5_rom, m5_ram;
    int m1_en, m1_lo, m1_hi, m1_mode;
    int mr_en, mr_rom, mr_ram, mr_rum;

    task automatic mdl_rst();
        m5_en = 0; m5_rom = 1; m5_ram = 0;
        m1_en = 0; m1_lo = 1; m1_hi = 0; m1_mode = 0;
        mr_en = 0; mr_rom = 1; mr_ram = 0; mr_rum = 0;
    endtask

    // Apply one committed write at CPU address a (only the top nibble matters).
    task automatic mdl_wr(input int a, input int d);
        int n;
        n = (a / 4096) % 16;
        if (n >= 8) return;
        if (n / 2 == 0) begin
            m5_en = (d % 16 == 10); m1_en = m5_en; mr_en = m5_en;
        end
        if (n == 2) begin
            m5_rom = (m5_rom / 256) * 256 + d;
            mr_rom = (mr_rom / 256) * 256 + d;
        end
        if (n == 3) begin
            m5_rom = m5_rom % 256 + (d % 2) * 256;
            mr_rom = mr_rom % 256 + (d % 2) * 256;
        end
        if (n / 2 == 2) begin
            m5_ram = d % 16;
            mr_ram = d % 8;
            mr_rum = (d / 8) % 2;
            m1_hi  = d % 4;
        end
        if (n / 2 == 1) begin
            m1_lo = d % 32;
            if (m1_lo == 0) m1_lo = 1;
        end
        if (n / 2 == 3) m1_mode = d % 2;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic look(input logic [3:0] a, input logic cs);
        gb_addr = a;
        gb_cs_n = cs;
        #2;
    endtask

    // Compare every output of every instance with the model at A14=0 and A14=1.
    task automatic probe(input string tg);
        int ecs;
        for (int a14 = 0; a14 < 2; a14++) begin
            look(a14 ? 4'h4 : 4'h0, 1'($urandom_range(0, 1)));
            chk({tg, "/m5.rom"}, 32'(rom5_o), a14 ? m5_rom : 0);
            chk({tg, "/m5.ram"}, 32'(ram5_o), m5_ram);
            ecs = (m5_en != 0 && gb_cs_n == 1'b0) ? 0 : 1;
            chk({tg, "/m5.cs"},  32'(cs5_o), ecs);
            chk({tg, "/m5.rum"}, 32'(rum5_o), 0);
            chk({tg, "/m1.rom"}, 32'(rom1_o),
                a14 ? (m1_hi * 32 + m1_lo) : (m1_mode ? m1_hi * 32 : 0));
            chk({tg, "/m1.ram"}, 32'(ram1_o), m1_mode ? m1_hi : 0);
            ecs = (m1_en != 0 && gb_cs_n == 1'b0) ? 0 : 1;
            chk({tg, "/m1.cs"},  32'(cs1_o), ecs);
            chk({tg, "/m1.rum"}, 32'(rum1_o), 0);
            chk({tg, "/mr.rom"}, 32'(romr_o), a14 ? mr_rom : 0);
            chk({tg, "/mr.ram"}, 32'(ramr_o), mr_ram);
            ecs = (mr_en != 0 && gb_cs_n == 1'b0) ? 0 : 1;
            chk({tg, "/mr.cs"},  32'(csr_o), ecs);
            chk({tg, "/mr.rum"}, 32'(rumr_o), mr_rum);
        end
    endtask

    // One bus write with wr_n low for lo clock edges. Pulses of 3+ edges with
    // A15=0 must commit exactly once; a single-edge pulse is a glitch.
    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d, input int lo);
        int c5, c1, cr, ex;
        @(posedge clk); #1;
        gb_addr = a[15:12];
        gb_data = d;
        c5 = n5; c1 = n1; cr = nr;
        @(posedge clk); #1;
        gb_wr_n = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
        gb_wr_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        ex = (a[15] == 1'b0 && lo >= 3) ? 1 : 0;
        if (ex != 0) mdl_wr(int'(a), int'(d));
        chk($sformatf("cfg5@%h", a), n5 - c5, ex);
        chk($sformatf("cfg1@%h", a), n1 - c1, ex);
        chk($sformatf("cfgr@%h", a), nr - cr, ex);
    endtask

    initial begin
        int c5, c1, cr, lo;
        logic [15:0] ra;
        logic [7:0]  rd;

        rst_n = 1'b0; gb_addr = 4'h0; gb_data = 8'h00; gb_wr_n = 1'b1; gb_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mdl_rst();
        chk("rst.cfg", 32'({cfg5_o, cfg1_o, cfgr_o}), 0);
        look(4'h4, 1'b0);
        chk("rst.rom5", 32'(rom5_o), 1);
        chk("rst.rom1", 32'(rom1_o), 1);
        chk("rst.cs5", 32'(cs5_o), 1);
        probe("rst");

        // RAM enable
        bus_wr(16'h0000, 8'h0A, 5);
        look(4'h0, 1'b0);
        chk("ramen.on", 32'(cs5_o), 0);
        bus_wr(16'h0000, 8'h00, 5);
        look(4'h0, 1'b0);
        chk("ramen.off", 32'(cs5_o), 1);
        probe("ramen");

        // MBC5 9-bit ROM bank
        bus_wr(16'h2000, 8'hFF, 4);
        bus_wr(16'h3000, 8'h01, 4);
        look(4'h4, 1'b1);
        chk("m5.rom1ff", 32'(rom5_o), 32'h1FF);
        look(4'h0, 1'b1);
        chk("m5.rom_a14lo", 32'(rom5_o), 0);
        probe("rom5");

        // MBC1 zero-to-one, hi2 and mode
        bus_wr(16'h2000, 8'h00, 6);
        look(4'h4, 1'b1);
        chk("m1.zero_is_1", 32'(rom1_o), 1);
        bus_wr(16'h4000, 8'h03, 6);
        bus_wr(16'h6000, 8'h01, 6);
        look(4'h4, 1'b1);
        chk("m1.ram3", 32'(ram1_o), 3);
        chk("m1.rom61", 32'(rom1_o), 32'h61);
        look(4'h0, 1'b1);
        chk("m1.mode1_a14lo", 32'(rom1_o), 32'h60);
        probe("mbc1");

        // Rumble
        bus_wr(16'h4000, 8'h0B, 5);
        look(4'h4, 1'b1);
        chk("mr.rumble", 32'(rumr_o), 1);
        chk("mr.ram3", 32'(ramr_o), 3);
        probe("rumble");

        // Glitch, long pulse, A15=1 write
        bus_wr(16'h2000, 8'h07, 1);
        probe("glitch");
        bus_wr(16'h2000, 8'h09, 20);
        probe("long");
        bus_wr(16'hA000, 8'h55, 5);
        probe("a15");

        // Reset in SETTLE, then wr_n held low through release
        @(posedge clk); #1;
        gb_addr = 4'h2; gb_data = 8'h05;
        c5 = n5; c1 = n1; cr = nr;
        @(posedge clk); #1;
        gb_wr_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mdl_rst();
        repeat (10) @(posedge clk);
        #1;
        chk("rstw.cfg5", n5 - c5, 0);
        chk("rstw.cfg1", n1 - c1, 0);
        chk("rstw.cfgr", nr - cr, 0);
        probe("rstw");
        gb_addr = 4'h2;
        gb_wr_n = 1'b1;
        repeat (4) @(posedge clk);
        bus_wr(16'h2000, 8'h05, 5);
        probe("rstw2");

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rd = 8'($urandom);
            lo = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(3, 20));
            bus_wr(ra, rd, lo);
            probe($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/gb_mbc_ctrl.md
GB_MBC_CTRL -- requirements
Module: gb_mbc_ctrl

Interface
REQ-001 Parameter ROM_BANK_W, default 9: ROM bank register width, range 5..9.
REQ-002 Parameter RAM_BANK_W, default 4: RAM bank register width, range 2..4.
REQ-003 Parameter MBC_TYPE, default 5: register map; 1 = MBC1, 5 = MBC5.
REQ-004 Parameter RUMBLE, default 0: if 1 and MBC_TYPE=5, RAM bank bit 3 drives rumble instead of addressing.
REQ-005 Parameter SETTLE, default 2: synchronized cycles wr_n must stay low before commit, range 1..7.
REQ-006 Port clk, input, 1: system clock, at least 8x the GB bus rate.
REQ-007 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-008 Port gb_addr, input, 4: GB A15..A12, asynchronous.
REQ-009 Port gb_data, input, 8: GB D7..D0, asynchronous.
REQ-010 Port gb_wr_n, input, 1: GB write strobe, asynchronous, active-low.
REQ-011 Port gb_cs_n, input, 1: GB external-RAM chip select, active-low.
REQ-012 Port rom_bank, output, ROM_BANK_W: mapped ROM A22..A14.
REQ-013 Port ram_bank, output, RAM_BANK_W: mapped RAM bank.
REQ-014 Port ram_cs_n, output, 1: cartridge RAM select, active-low.
REQ-015 Port rumble, output, 1: rumble motor drive, constant 0 when unused.
REQ-016 Port cfg_wr, output, 1: one-cycle pulse on each register commit.

Function
REQ-017 gb_wr_n, gb_addr and gb_data pass through 2-flop synchronizers; all decoding uses the synchronized values.
REQ-018 Write FSM states: IDLE, SETTLE, COMMIT, WAIT_HI.
REQ-019 IDLE -> SETTLE when sync wr_n falls with sync A15=0; writes with A15=1 are ignored.
REQ-020 SETTLE counts cycles with wr_n low; it reaches COMMIT at count SETTLE and returns to IDLE if wr_n rises first (glitch, no commit).
REQ-021 COMMIT lasts one cycle: it updates one register from the sync address/data, pulses cfg_wr, then goes to WAIT_HI.
REQ-022 WAIT_HI -> IDLE when sync wr_n=1; exactly one commit per write pulse regardless of pulse length.
REQ-023 RAM enable register (A15..A13=000, both types): set when data[3:0]=0xA, otherwise cleared.
REQ-024 MBC5, A15..A12=0010: ROM bank[7:0] <= data; A15..A12=0011: ROM bank[8] <= data[0] (ignored if ROM_BANK_W<9).
REQ-025 MBC5, A15..A13=010: RAM bank <= data[RAM_BANK_W-1:0]; with RUMBLE=1, rumble <= data[3] and RAM bank bit 3 is forced 0.
REQ-026 MBC5, A15..A13=011: no effect; cfg_wr still pulses.
REQ-027 MBC1, A15..A13=001: ROM low5 <= data[4:0], and a written 0 is stored as 1.
REQ-028 MBC1, A15..A13=010: hi2 <= data[1:0].
REQ-029 MBC1, A15..A13=011: mode <= data[0].
REQ-030 MBC1 mapping: rom_bank = {hi2, low5} truncated to ROM_BANK_W. ram_bank = mode ? hi2 : 0. When A14=0 and mode=1, rom_bank upper bits = hi2 and low5 = 0.
REQ-031 Address-dependent outputs: when gb_addr[2] (A14) = 0, rom_bank is 0, except the MBC1 mode=1 case in REQ-030. This path is combinational from raw pins; only bank registers are sequential.
REQ-032 ram_cs_n = NOT(ram_en AND NOT gb_cs_n), combinational.
REQ-033 A commit becomes visible on outputs the cycle after COMMIT. Worst-case latency from raw wr_n fall is 2 + SETTLE + 1 cycles.
REQ-034 Values wider than a register are truncated (upper bits dropped); there is no wrap or saturation.

Reset
REQ-035 While rst_n=0 at clk edge: FSM=IDLE, ROM bank=1 (MBC1 low5=1; MBC5 bank=1), RAM bank=0, hi2=0, mode=0, ram_en=0, rumble=0, cfg_wr=0, synchronizers=1.
REQ-036 Reset asserted mid-write aborts the write without commit. After release, a still-low wr_n is not treated as a new write until it rises.

Structure
REQ-037 Shared package gb_mbc_pkg holds the FSM state enum, MBC_TYPE constants and register-region decode constants.
REQ-038 Sub-module gb_sync2, a parametrised-width 2-flop synchronizer, is instantiated for the wr_n, addr and data bundles.

Verification
REQ-039 Scenario, MBC5: write 0x0A to 0x0000 with gb_cs_n=0 -> ram_cs_n=0; write 0x00 -> ram_cs_n=1.
REQ-040 Scenario, MBC5: write 0x2000<-0xFF, then 0x3000<-0x01, A14=1 -> rom_bank=0x1FF; with A14=0 -> rom_bank=0.
REQ-041 Scenario, MBC1: write 0x2000<-0x00 -> rom_bank=1; write 0x4000<-0x03 and 0x6000<-0x01 -> ram_bank=3, rom_bank=0x61 at A14=1.
REQ-042 Scenario, glitch: wr_n low for SETTLE-1 sync cycles -> no cfg_wr and registers unchanged; a 20-cycle-long pulse -> exactly one cfg_wr.
REQ-043 Scenario, RUMBLE=1 MBC5: write 0x4000<-0x0B -> rumble=1, ram_bank=0x3.
REQ-044 Scenario, reset: rst_n=0 during SETTLE -> no commit. With wr_n held low through release -> no commit until wr_n rises and falls again.
